// File: rtl/fp_expand_seq_if.sv
// Handshake and data bundle for the float-to-linear expander.
// The master drives input words and out_ready; the slave is the expander itself.
interface fp_expand_seq_if #(
   parameter int EXP_W = 3,
   parameter int SIG_W = 4,
   parameter int OUT_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [EXP_W-1:0] in_exp;
   logic [SIG_W-1:0] in_sig;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             busy;

   modport master (
      output in_valid, in_sign, in_exp, in_sig, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_sig, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fp_expand_seq.sv
// Iterative float-to-linear expander: {sign, exp, sig} -> sign * sig * 2^exp,
// one left shift per clock, sign applied in a final cycle.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | shifting acc left until count reaches 0, then applying the sign
// OUT   | result presented, held until out_ready
module fp_expand_seq #(
   parameter int EXP_W = 3,
   parameter int SIG_W = 4,
   parameter int OUT_W = 12
) (
   input logic             clk,
   input logic             rst_n,
   fp_expand_seq_if.slave  bus
);

   generate
      if (OUT_W < SIG_W + (1 << EXP_W)) begin : g_width_check
         $error("fp_expand_seq: OUT_W too small for SIG_W + 2^EXP_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [OUT_W-1:0]   r_acc;
   logic [OUT_W-1:0]   w_acc_nxt;
   logic [EXP_W-1:0]   r_count;
   logic [EXP_W-1:0]   w_count_nxt;
   logic               r_sign;
   logic               w_sign_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_sign  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
         r_sign  <= w_sign_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count;
      w_sign_nxt  = r_sign;
      case (r_state)
         IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone means accept
            if (bus.in_valid) begin
               w_acc_nxt   = OUT_W'(bus.in_sig);
               w_count_nxt = bus.in_exp;
               w_sign_nxt  = bus.in_sign;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (r_count != '0) begin
               w_acc_nxt   = r_acc << 1;
               w_count_nxt = r_count - EXP_W'(1);
            end else begin
               if (r_sign) begin
                  w_acc_nxt = -r_acc;
               end
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // out_data stays on acc after the handshake; it is only meaningful with out_valid
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == OUT);
   assign bus.out_data  = r_acc;
   assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fp_expand_seq.sv
// Self-checking bench for fp_expand_seq: directed vector table, backpressure and
// reset corner cases, then every float code in random order against a model.
module tb_fp_expand_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   fp_expand_seq_if bus ();

   fp_expand_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         s;
      int         e;
      int         g;
      logic [11:0] want;
      int         stall;
   } vec_t;

   vec_t tab[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference: signed product computed with plain integer arithmetic.
   function automatic logic [11:0] model(input bit s, input int e, input int g);
      int v;
      v = g * (2 ** e);
      if (s) v = -v;
      return v[11:0];
   endfunction

   // Called #1 after a rising edge with the block idle. Latency is counted as
   // the edges after the accept edge up to the edge at which the consumer
   // first samples out_valid high.
   task automatic run_word(input bit s, input int e, input int g, input logic [11:0] want,
                           input int stall, input string tag);
      int n;
      chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
      bus.in_sign   = s;
      bus.in_exp    = 3'(e);
      bus.in_sig    = 4'(g);
      bus.in_valid  = 1'b1;
      bus.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'($urandom);
      bus.in_exp   = 3'($urandom);
      bus.in_sig   = 4'($urandom);
      chk({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n + 1), 32'(e + 2));
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(want));
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sign  = 1'($urandom);
         bus.in_exp   = 3'($urandom);
         bus.in_sig   = 4'($urandom);
         @(posedge clk); #1;
         chk({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, " stall out_data"}, 32'(bus.out_data), 32'(want));
         chk({tag, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
         chk({tag, " stall busy"}, 32'(bus.busy), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
      chk({tag, " out_data held"}, 32'(bus.out_data), 32'(want));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int perm[256];
      int c;
      int j;
      int t;

      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_sig    = '0;
      bus.out_ready = 1'b0;

      #1 rst_n = 1'b0;
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data", 32'(bus.out_data), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      tab.push_back('{1'b0, 5, 13, 12'h1A0, 0});
      tab.push_back('{1'b1, 5, 13, 12'hE60, 0});
      tab.push_back('{1'b1, 7, 15, 12'h880, 0});
      tab.push_back('{1'b0, 7, 15, 12'h780, 0});
      tab.push_back('{1'b1, 0,  0, 12'h000, 0});
      tab.push_back('{1'b0, 3,  0, 12'h000, 0});
      tab.push_back('{1'b0, 2,  9, 12'h024, 6});
      tab.push_back('{1'b1, 1,  3, 12'hFFA, 0});
      tab.push_back('{1'b0, 0,  1, 12'h001, 0});

      foreach (tab[k]) begin
         run_word(tab[k].s, tab[k].e, tab[k].g, tab[k].want, tab[k].stall,
                  $sformatf("vec%0d", k));
      end

      // Asynchronous reset after two shifts of an exp=6 word.
      bus.in_sign   = 1'b0;
      bus.in_exp    = 3'd6;
      bus.in_sig    = 4'd5;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort out_data", 32'(bus.out_data), 32'd0);
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-abort out_valid", 32'(bus.out_valid), 32'd0);
      run_word(1'b0, 4, 9, 12'h090, 0, "post-abort");

      // Every float code once, random order, random backpressure.
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         c = perm[i];
         run_word(c[7], int'(c[6:4]), int'(c[3:0]), model(c[7], int'(c[6:4]), int'(c[3:0])),
                  int'($urandom_range(2, 0)), $sformatf("code%02h", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
